// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-way round-robin arbiter with bounded hold time
// Registered one-hot grant plus index; forced release after HOLD_MAX cycles.
module rr_arbiter_8 #(
   parameter int HOLD_MAX = 16,
   parameter int CNT_W    = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [7:0] gnt,
   output logic [2:0] gnt_idx,
   output logic       gnt_valid,
   output logic       timeout
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

   state_t           state_q, state_d;
   logic [7:0]       gnt_q, gnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             to_q, to_d;

   logic [2:0]       win;
   logic             win_found;
   logic [2:0]       cand;

   // Search upward from the priority pointer with wrap; first set bit wins.
   always_comb begin
      win       = 3'd0;
      win_found = 1'b0;
      cand      = 3'd0;
      for (int i = 0; i < 8; i++) begin
         cand = ptr_q + 3'(i);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win       = cand;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      to_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (win_found) begin
               state_d = GRANT;
               idx_d   = win;
               gnt_d   = 8'd1 << win;
               cnt_d   = '0;
            end
         end
         GRANT: begin
            // done outranks withdrawal, which outranks the hold limit.
            if (done || !req[idx_q] || (cnt_q == HOLD_LAST)) begin
               state_d = IDLE;
               gnt_d   = 8'h00;
               ptr_d   = idx_q + 3'd1;
               to_d    = !done && req[idx_q];
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= 8'h00;
         idx_q   <= 3'd0;
         ptr_q   <= 3'd0;
         cnt_q   <= '0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         to_q    <= to_d;
      end
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = idx_q;
   assign gnt_valid = |gnt_q;
   assign timeout   = to_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - scoreboard bench for rr_arbiter_8
// Expected outputs are queued when inputs are driven and popped after the edge.
module tb_rr_arbiter_8;

   logic       clk;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       timeout;

   typedef struct packed {
      logic [7:0] g;
      logic [2:0] idx;
      logic       v;
      logic       to;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   rr_arbiter_8 #(.HOLD_MAX(16), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .done      (done),
      .gnt       (gnt),
      .gnt_idx   (gnt_idx),
      .gnt_valid (gnt_valid),
      .timeout   (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(input logic [7:0] g, input logic [2:0] idx,
                               input logic v, input logic to);
      exp_t e;
      e.g = g; e.idx = idx; e.v = v; e.to = to;
      return e;
   endfunction

   task automatic cyc();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic apply_reset();
      rst = 1'b1; req = 8'h00; done = 1'b0;
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      exp_t e;
      rst = 1'b1; req = 8'h00; done = 1'b0;
      q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
      cyc();
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         e = q.pop_front();
         total++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            bad++;
            $display("FAIL reset step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     i, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
         end
         if (i < 5) begin
            q.push_back(mk(8'h00, 3'd0, 1'b0, 1'b0));
            cyc();
         end
      end
   endtask

   task automatic test_pair_done();
      exp_t e;
      logic [2:0] seq [3] = '{3'd2, 3'd5, 3'd2};
      req = 8'h24;
      for (int n = 0; n < 3; n++) begin
         for (int j = 0; j < 5; j++) begin
            done = (j == 4);
            if (j < 4) q.push_back(mk(8'd1 << seq[n], seq[n], 1'b1, 1'b0));
            else       q.push_back(mk(8'h00, seq[n], 1'b0, 1'b0));
            cyc();
            e = q.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
               bad++;
               $display("FAIL pair_done grant %0d step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                        n, j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
            end
         end
      end
      done = 1'b0;
   endtask

   task automatic test_fairness();
      exp_t e;
      logic [2:0] g;
      apply_reset();
      req = 8'hFF;
      for (int n = 0; n < 9; n++) begin
         g = 3'(n);
         for (int j = 0; j < 2; j++) begin
            done = (j == 1);
            if (j == 0) q.push_back(mk(8'd1 << g, g, 1'b1, 1'b0));
            else        q.push_back(mk(8'h00, g, 1'b0, 1'b0));
            cyc();
            e = q.pop_front();
            total++;
            if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
               bad++;
               $display("FAIL fairness grant %0d step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                        n, j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
            end
         end
      end
      done = 1'b0;
   endtask

   task automatic test_timeout();
      exp_t e;
      apply_reset();
      req = 8'h08;
      for (int j = 0; j < 18; j++) begin
         if (j == 16) q.push_back(mk(8'h00, 3'd3, 1'b0, 1'b1));
         else         q.push_back(mk(8'h08, 3'd3, 1'b1, 1'b0));
         cyc();
         e = q.pop_front();
         total++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            bad++;
            $display("FAIL timeout step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
         end
      end
   endtask

   task automatic test_done_beats_timeout();
      exp_t e;
      apply_reset();
      req = 8'h40;
      for (int j = 0; j < 18; j++) begin
         done = (j == 16);
         if (j == 16) req = 8'hC0;
         if (j < 16)       q.push_back(mk(8'h40, 3'd6, 1'b1, 1'b0));
         else if (j == 16) q.push_back(mk(8'h00, 3'd6, 1'b0, 1'b0));
         else              q.push_back(mk(8'h80, 3'd7, 1'b1, 1'b0));
         cyc();
         e = q.pop_front();
         total++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            bad++;
            $display("FAIL done_vs_timeout step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
         end
      end
      done = 1'b0;
   endtask

   task automatic test_withdraw();
      exp_t e;
      logic [7:0] reqs [3] = '{8'h01, 8'h00, 8'h03};
      exp_t       exps [3];
      exps[0] = mk(8'h01, 3'd0, 1'b1, 1'b0);
      exps[1] = mk(8'h00, 3'd0, 1'b0, 1'b0);
      exps[2] = mk(8'h02, 3'd1, 1'b1, 1'b0);
      apply_reset();
      for (int j = 0; j < 3; j++) begin
         req = reqs[j];
         q.push_back(exps[j]);
         cyc();
         e = q.pop_front();
         total++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            bad++;
            $display("FAIL withdraw step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
         end
      end
   endtask

   task automatic test_reset_mid_grant();
      exp_t e;
      logic [7:0] reqs  [6] = '{8'h10, 8'h10, 8'h02, 8'h02, 8'h02, 8'h82};
      logic       dones [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      logic       rsts  [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      exp_t       exps  [6];
      exps[0] = mk(8'h10, 3'd4, 1'b1, 1'b0);
      exps[1] = mk(8'h00, 3'd4, 1'b0, 1'b0);
      exps[2] = mk(8'h02, 3'd1, 1'b1, 1'b0);
      exps[3] = mk(8'h02, 3'd1, 1'b1, 1'b0);
      exps[4] = mk(8'h00, 3'd0, 1'b0, 1'b0);
      exps[5] = mk(8'h02, 3'd1, 1'b1, 1'b0);
      apply_reset();
      for (int j = 0; j < 6; j++) begin
         req = reqs[j]; done = dones[j]; rst = rsts[j];
         q.push_back(exps[j]);
         cyc();
         e = q.pop_front();
         total++;
         if ({gnt, gnt_idx, gnt_valid, timeout} !== e) begin
            bad++;
            $display("FAIL reset_mid_grant step %0d: got gnt=%h idx=%0d valid=%b to=%b, want gnt=%h idx=%0d valid=%b to=%b",
                     j, gnt, gnt_idx, gnt_valid, timeout, e.g, e.idx, e.v, e.to);
         end
      end
      rst = 1'b0; done = 1'b0;
   endtask

   initial begin
      rst = 1'b1; req = 8'h00; done = 1'b0;
      @(negedge clk);
      test_reset();
      test_pair_done();
      test_fairness();
      test_timeout();
      test_done_beats_timeout();
      test_withdraw();
      test_reset_mid_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
